// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU RAM arbiter.
//   AddrWidth / DataWidth : RAM geometry (12-bit address, 4-bit word)
//   mem_owner_t           : owner of a RAM cycle, also the grant_state encoding
//   read_tag_t            : {valid, owner} carried alongside each read in flight
package mem_arbiter_pkg;

   localparam int unsigned AddrWidth      = 12;
   localparam int unsigned DataWidth      = 4;
   localparam int unsigned StarveCntWidth = 8;

   typedef enum logic [1:0] {
      OWNER_IDLE = 2'd0,
      OWNER_CPU  = 2'd1,
      OWNER_AUX  = 2'd2
   } mem_owner_t;

   typedef struct packed {
      logic       valid;
      mem_owner_t owner;
   } read_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU, the aux requester, the arbiter and the RAM macro.
//   master : requester/RAM side (drives CPU and aux strobes, RAM read data)
//   slave  : arbiter side (drives RAM address/write controls, read returns, status)
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic                 clk_en;
   logic                 cpu_read_en;
   logic                 cpu_write_en;
   logic [AddrWidth-1:0] cpu_addr;
   logic [DataWidth-1:0] cpu_write_data;
   logic [DataWidth-1:0] cpu_read_data;

   logic                 aux_req;
   logic                 aux_we;
   logic [AddrWidth-1:0] aux_addr;
   logic [DataWidth-1:0] aux_write_data;
   logic                 aux_ack;
   logic [DataWidth-1:0] aux_read_data;
   logic                 aux_rvalid;
   logic                 aux_starved;

   logic [1:0]           grant_state;

   logic [AddrWidth-1:0] ram_addr;
   logic                 ram_write_en;
   logic [DataWidth-1:0] ram_write_data;
   logic [DataWidth-1:0] ram_read_data;

   modport master (
      output clk_en, cpu_read_en, cpu_write_en, cpu_addr, cpu_write_data,
      output aux_req, aux_we, aux_addr, aux_write_data,
      output ram_read_data,
      input  cpu_read_data, aux_ack, aux_read_data, aux_rvalid, aux_starved,
      input  grant_state, ram_addr, ram_write_en, ram_write_data
   );

   modport slave (
      input  clk_en, cpu_read_en, cpu_write_en, cpu_addr, cpu_write_data,
      input  aux_req, aux_we, aux_addr, aux_write_data,
      input  ram_read_data,
      output cpu_read_data, aux_ack, aux_read_data, aux_rvalid, aux_starved,
      output grant_state, ram_addr, ram_write_en, ram_write_data
   );

endinterface

// File: rtl/mem_arbiter_read_tag_pipe.sv
// Read tag pipeline: a Depth-stage shift register of {valid, owner}, one entry
// per RAM cycle. tag_out is the tag whose RAM data is on ram_read_data this cycle.
//   clk, reset_n : clock, async active-low clear (drops all tags in flight)
//   tag_in       : tag for the RAM cycle being issued now
//   tag_out      : tag leaving the pipe at the next edge
module mem_arbiter_read_tag_pipe
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic      clk,
   input  logic      reset_n,
   input  read_tag_t tag_in,
   output read_tag_t tag_out
);

   read_tag_t stage_q [Depth];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_in;
         for (int unsigned i = 1; i < Depth; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_out = stage_q[Depth-1];

endmodule

// File: rtl/mem_arbiter.sv
// CPU RAM arbiter: the CPU owns every cycle it strobes (with clk_en); the aux
// requester gets the remaining cycles via level req / one-cycle ack.
//   clk, reset_n : system clock, async active-low reset
//   bus (slave)  : CPU bus, aux req/ack bus, RAM macro port and status outputs
// Read returns: a read issued in cycle t has RAM data in cycle t+RAM_LATENCY;
// it is registered at the end of that cycle, so cpu_read_data / aux_rvalid
// change on the edge RAM_LATENCY edges after the issue edge.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned RAM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 255
) (
   input logic          clk,
   input logic          reset_n,
   mem_arbiter_if.slave bus
);

   localparam logic [StarveCntWidth-1:0] StarveMax = StarveCntWidth'(STARVE_LIMIT);

   logic                      cpu_slot;
   logic                      aux_grant;
   logic [AddrWidth-1:0]      ram_addr;
   logic                      ram_we;
   logic [DataWidth-1:0]      ram_wdata;
   logic [AddrWidth-1:0]      addr_q;
   mem_owner_t                grant_d, grant_q;
   read_tag_t                 tag_in, tag_out;
   logic [StarveCntWidth-1:0] starve_d, starve_q;
   logic [DataWidth-1:0]      cpu_rdata_q, aux_rdata_q;
   logic                      aux_rvalid_q;

   assign cpu_slot  = bus.clk_en & (bus.cpu_read_en | bus.cpu_write_en);
   assign aux_grant = ~cpu_slot & bus.aux_req;

   // RAM port mux. An unused cycle keeps the last address so the macro sees
   // no spurious address toggling.
   always_comb begin
      ram_addr  = addr_q;
      ram_we    = 1'b0;
      ram_wdata = bus.cpu_write_data;
      grant_d   = OWNER_IDLE;
      if (cpu_slot) begin
         ram_addr  = bus.cpu_addr;
         ram_we    = bus.cpu_write_en;
         ram_wdata = bus.cpu_write_data;
         grant_d   = OWNER_CPU;
      end else if (aux_grant) begin
         ram_addr  = bus.aux_addr;
         ram_we    = bus.aux_we;
         ram_wdata = bus.aux_write_data;
         grant_d   = OWNER_AUX;
      end
   end

   // A CPU cycle with both strobes is a write; it never also tags a read.
   always_comb begin
      tag_in.owner = grant_d;
      tag_in.valid = cpu_slot ? (bus.cpu_read_en & ~bus.cpu_write_en)
                              : (aux_grant & ~bus.aux_we);
   end

   mem_arbiter_read_tag_pipe #(
      .Depth (RAM_LATENCY)
   ) u_read_tag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Wait counter: counts cycles with an outstanding, unacknowledged request.
   always_comb begin
      starve_d = starve_q;
      if (!bus.aux_req || aux_grant) begin
         starve_d = '0;
      end else if (starve_q != StarveMax) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q       <= '0;
         grant_q      <= OWNER_IDLE;
         starve_q     <= '0;
         cpu_rdata_q  <= '0;
         aux_rdata_q  <= '0;
         aux_rvalid_q <= 1'b0;
      end else begin
         addr_q       <= ram_addr;
         grant_q      <= grant_d;
         starve_q     <= starve_d;
         aux_rvalid_q <= 1'b0;
         if (tag_out.valid) begin
            if (tag_out.owner == OWNER_AUX) begin
               aux_rdata_q  <= bus.ram_read_data;
               aux_rvalid_q <= 1'b1;
            end else begin
               cpu_rdata_q <= bus.ram_read_data;
            end
         end
      end
   end

   assign bus.ram_addr       = ram_addr;
   assign bus.ram_write_en   = ram_we;
   assign bus.ram_write_data = ram_wdata;
   assign bus.aux_ack        = aux_grant;
   assign bus.cpu_read_data  = cpu_rdata_q;
   assign bus.aux_read_data  = aux_rdata_q;
   assign bus.aux_rvalid     = aux_rvalid_q;
   assign bus.aux_starved    = (starve_q == StarveMax);
   assign bus.grant_state    = grant_q;

endmodule
